// File: rtl/ysyx_210184_axi_pkg.sv
// Shared definitions for the AXI burst master: FSM encoding, AXI field
// constants and the narrow (32-bit device) address decode.
package ysyx_210184_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_AR,
      ST_R,
      ST_AW_W,
      ST_B
   } state_e;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [2:0] SIZE_8B    = 3'b011;

   // Device windows that only accept single 32-bit beats.
   function automatic logic is_narrow(input logic [63:0] addr);
      return (addr[63:13] == 51'h8000) || (addr[63:28] == 36'h3);
   endfunction

endpackage

// File: rtl/ysyx_210184_axi_burst_master_if.sv
// AXI4 master-side channel bundle (AW, W, B, AR, R) with master/slave views.
interface ysyx_210184_axi_burst_master_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_W   = 4
);
   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic [ID_W-1:0]   aw_id;
   logic [7:0]        aw_len;
   logic [2:0]        aw_size;
   logic [1:0]        aw_burst;

   logic                w_valid;
   logic                w_ready;
   logic [DATA_W-1:0]   w_data;
   logic [DATA_W/8-1:0] w_strb;
   logic                w_last;

   logic            b_valid;
   logic            b_ready;
   logic [1:0]      b_resp;
   logic [ID_W-1:0] b_id;

   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [ID_W-1:0]   ar_id;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;

   logic              r_valid;
   logic              r_ready;
   logic [1:0]        r_resp;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic [ID_W-1:0]   r_id;

   modport master (
      output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
      input  aw_ready,
      output w_valid, w_data, w_strb, w_last,
      input  w_ready,
      input  b_valid, b_resp, b_id,
      output b_ready,
      output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
      input  ar_ready,
      input  r_valid, r_resp, r_data, r_last, r_id,
      output r_ready
   );

   modport slave (
      input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst,
      output aw_ready,
      input  w_valid, w_data, w_strb, w_last,
      output w_ready,
      output b_valid, b_resp, b_id,
      input  b_ready,
      input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst,
      output ar_ready,
      output r_valid, r_resp, r_data, r_last, r_id,
      input  r_ready
   );
endinterface

// File: rtl/ysyx_210184_axi_arb.sv
// Post-reset hold-off counter plus fixed-priority (D over I) request arbiter.
module ysyx_210184_axi_arb #(
   parameter int unsigned RST_DELAY = 300
) (
   input  logic clk,
   input  logic rst,
   input  logic arb_en_i,
   input  logic i_valid_i,
   input  logic d_valid_i,
   output logic delay_done_o,
   output logic grant_i_o,
   output logic grant_d_o
);

   localparam int unsigned CNT_W = (RST_DELAY < 1) ? 1 : $clog2(RST_DELAY + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RST_DELAY);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign delay_done_o = (cnt_q == CNT_MAX);
   assign grant_d_o    = arb_en_i & d_valid_i;
   assign grant_i_o    = arb_en_i & i_valid_i & ~d_valid_i;

endmodule

// File: rtl/ysyx_210184_axi_burst_master.sv
// Two-client (I read-only, D read/write) AXI4 master, one transaction in flight.
module ysyx_210184_axi_burst_master
   import ysyx_210184_axi_pkg::*;
#(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned ID_W      = 4,
   parameter int unsigned RST_DELAY = 300
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   input  logic [7:0]          i_req_len,

   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_req_we,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [7:0]          d_req_len,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_wstrb,

   output logic                rsp_valid,
   output logic                rsp_src,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_last,
   output logic                rsp_err,
   output logic                wr_done,
   output logic                wr_err,

   ysyx_210184_axi_burst_master_if.master axi
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam logic [ID_W-1:0] ID_I = '0;
   localparam logic [ID_W-1:0] ID_D = ID_W'(1);

   state_e state_q, state_d;

   logic              delay_done, grant_i, grant_d, arb_en;
   logic [ADDR_W-1:0] sel_addr;
   logic [7:0]        sel_len;
   logic              sel_narrow;
   logic [2:0]        sel_size;
   logic              aw_fin, w_fin;

   logic              arvalid_q, awvalid_q, wvalid_q, src_q;
   logic [ADDR_W-1:0] araddr_q, awaddr_q;
   logic [ID_W-1:0]   arid_q;
   logic [7:0]        arlen_q;
   logic [2:0]        arsize_q, awsize_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;

   logic              rsp_valid_q, rsp_src_q, rsp_last_q, rsp_err_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              wr_done_q, wr_err_q;

   assign arb_en = (state_q == ST_ARB);

   ysyx_210184_axi_arb #(
      .RST_DELAY (RST_DELAY)
   ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .arb_en_i     (arb_en),
      .i_valid_i    (i_req_valid),
      .d_valid_i    (d_req_valid),
      .delay_done_o (delay_done),
      .grant_i_o    (grant_i),
      .grant_d_o    (grant_d)
   );

   assign i_req_ready = grant_i;
   assign d_req_ready = grant_d;

   assign sel_addr   = grant_d ? d_req_addr : i_req_addr;
   assign sel_len    = grant_d ? d_req_len  : i_req_len;
   assign sel_narrow = is_narrow(64'(sel_addr));
   assign sel_size   = sel_narrow ? SIZE_4B : SIZE_8B;

   // A channel already handshaken earlier counts as finished.
   assign aw_fin = ~awvalid_q | axi.aw_ready;
   assign w_fin  = ~wvalid_q  | axi.w_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (delay_done) state_d = ST_ARB;
         ST_ARB: begin
            if (grant_d && d_req_we)   state_d = ST_AW_W;
            else if (grant_d || grant_i) state_d = ST_AR;
         end
         ST_AR:   if (axi.ar_ready) state_d = ST_R;
         ST_R:    if (axi.r_valid && axi.r_last) state_d = ST_ARB;
         ST_AW_W: if (aw_fin && w_fin) state_d = ST_B;
         ST_B:    if (axi.b_valid) state_d = ST_ARB;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arvalid_q   <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         src_q       <= 1'b0;
         araddr_q    <= '0;
         awaddr_q    <= '0;
         arid_q      <= '0;
         arlen_q     <= '0;
         arsize_q    <= '0;
         awsize_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_src_q   <= 1'b0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         wr_done_q   <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
         wr_done_q   <= 1'b0;
         wr_err_q    <= 1'b0;
         unique case (state_q)
            ST_ARB: begin
               if (grant_d && d_req_we) begin
                  src_q     <= 1'b1;
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  awaddr_q  <= d_req_addr;
                  awsize_q  <= sel_size;
                  wdata_q   <= d_req_wdata;
                  wstrb_q   <= d_req_wstrb;
               end else if (grant_d || grant_i) begin
                  src_q     <= grant_d;
                  arvalid_q <= 1'b1;
                  araddr_q  <= sel_addr;
                  arid_q    <= grant_d ? ID_D : ID_I;
                  arsize_q  <= sel_size;
                  arlen_q   <= sel_narrow ? 8'd0 : sel_len;
               end
            end
            ST_AR: if (axi.ar_ready) arvalid_q <= 1'b0;
            ST_R: begin
               if (axi.r_valid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_src_q   <= src_q;
                  rsp_data_q  <= axi.r_data;
                  rsp_last_q  <= axi.r_last;
                  rsp_err_q   <= (axi.r_resp != RESP_OKAY) || (axi.r_id != arid_q);
               end
            end
            ST_AW_W: begin
               if (axi.aw_ready) awvalid_q <= 1'b0;
               if (axi.w_ready)  wvalid_q  <= 1'b0;
            end
            ST_B: begin
               if (axi.b_valid) begin
                  wr_done_q <= 1'b1;
                  wr_err_q  <= (axi.b_resp != RESP_OKAY) || (axi.b_id != ID_D);
               end
            end
            default: ;
         endcase
      end
   end

   assign axi.ar_valid = arvalid_q;
   assign axi.ar_addr  = araddr_q;
   assign axi.ar_id    = arid_q;
   assign axi.ar_len   = arlen_q;
   assign axi.ar_size  = arsize_q;
   assign axi.ar_burst = BURST_INCR;
   assign axi.r_ready  = (state_q == ST_R);

   assign axi.aw_valid = awvalid_q;
   assign axi.aw_addr  = awaddr_q;
   assign axi.aw_id    = ID_D;
   assign axi.aw_len   = 8'd0;
   assign axi.aw_size  = awsize_q;
   assign axi.aw_burst = BURST_INCR;
   assign axi.w_valid  = wvalid_q;
   assign axi.w_data   = wdata_q;
   assign axi.w_strb   = wstrb_q;
   assign axi.w_last   = 1'b1;
   assign axi.b_ready  = (state_q == ST_B);

   assign rsp_valid = rsp_valid_q;
   assign rsp_src   = rsp_src_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_err   = rsp_err_q;
   assign wr_done   = wr_done_q;
   assign wr_err    = wr_err_q;

endmodule
